// File: rtl/pwm_slot_if.sv
// MMIO slot bundle between the AXI MMIO controller and a slot peripheral.
// The controller drives requests; the slot answers with done/idle/error.
interface pwm_slot_if;
    logic        chip_select;
    logic        read;
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr_done;
    logic        rd_done;
    logic        idle;
    logic        transaction_completed;
    logic        slave_error;
    logic        decode_error;

    modport master (
        output chip_select, read, write, addr, wr_data,
        output transaction_completed,
        input  rd_data, wr_done, rd_done, idle,
        input  slave_error, decode_error
    );

    modport slave (
        input  chip_select, read, write, addr, wr_data,
        input  transaction_completed,
        output rd_data, wr_done, rd_done, idle,
        output slave_error, decode_error
    );
endinterface

// File: rtl/pwm_slot.sv
// Multi-channel PWM slot: shared prescaler and period counter,
// one duty register per channel, MMIO slot register access.
module pwm_slot #(
    parameter int NUM_CH     = 4,
    parameter int RES_BITS   = 8,
    parameter int DVSR_WIDTH = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    pwm_slot_if.slave         bus,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DONE = 1'b1;

    logic [0:0]            state;
    logic                  en;
    logic                  clr;
    logic [DVSR_WIDTH-1:0] dvsr;
    logic [DVSR_WIDTH-1:0] presc;
    logic [RES_BITS-1:0]   cnt;
    logic [RES_BITS:0]     duty [NUM_CH];

    logic              is_ctrl;
    logic              is_dvsr;
    logic              is_status;
    logic [NUM_CH-1:0] duty_sel;
    logic              hit;
    logic [31:0]       rd_mux;

    assign bus.idle = (state == S_IDLE);

    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            duty_sel[i] = (bus.addr == 8'(i + 2));
        is_ctrl   = (bus.addr == 8'h00);
        is_dvsr   = (bus.addr == 8'h01);
        is_status = (bus.addr == 8'h10);
        hit       = is_ctrl | is_dvsr | is_status | (|duty_sel);
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            is_ctrl:   rd_mux[0] = en;
            is_dvsr:   rd_mux[DVSR_WIDTH-1:0] = dvsr;
            is_status: rd_mux[RES_BITS-1:0] = cnt;
            |duty_sel: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (duty_sel[i])
                        rd_mux[RES_BITS:0] = duty[i];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state            <= S_IDLE;
            bus.wr_done      <= 1'b0;
            bus.rd_done      <= 1'b0;
            bus.rd_data      <= '0;
            bus.slave_error  <= 1'b0;
            bus.decode_error <= 1'b0;
            en               <= 1'b0;
            clr              <= 1'b0;
            dvsr             <= '0;
            for (int i = 0; i < NUM_CH; i++)
                duty[i] <= '0;
        end else begin
            clr <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.chip_select && (bus.read || bus.write)) begin
                    state <= S_DONE;
                    if (bus.read && bus.write) begin
                        bus.slave_error <= 1'b1;
                        bus.wr_done     <= 1'b1;
                    end else if (bus.read) begin
                        bus.rd_done      <= 1'b1;
                        bus.decode_error <= !hit;
                        bus.rd_data      <= rd_mux;
                    end else begin
                        bus.wr_done      <= 1'b1;
                        bus.decode_error <= !hit;
                        bus.slave_error  <= is_status;
                        if (is_ctrl) begin
                            en  <= bus.wr_data[0];
                            clr <= bus.wr_data[1];
                        end
                        if (is_dvsr)
                            dvsr <= bus.wr_data[DVSR_WIDTH-1:0];
                        for (int i = 0; i < NUM_CH; i++)
                            if (duty_sel[i])
                                duty[i] <= bus.wr_data[RES_BITS:0];
                    end
                end
            end else if (bus.transaction_completed) begin
                state            <= S_IDLE;
                bus.wr_done      <= 1'b0;
                bus.rd_done      <= 1'b0;
                bus.rd_data      <= '0;
                bus.slave_error  <= 1'b0;
                bus.decode_error <= 1'b0;
            end
        end
    end

    // >= rather than == so a DVSR shrink below presc cannot strand it
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            presc   <= '0;
            cnt     <= '0;
            pwm_out <= '0;
        end else begin
            if (clr) begin
                presc <= '0;
                cnt   <= '0;
            end else if (en) begin
                if (presc >= dvsr) begin
                    presc <= '0;
                    cnt   <= cnt + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            for (int i = 0; i < NUM_CH; i++)
                pwm_out[i] <= en && ({1'b0, cnt} < duty[i]);
        end
    end
endmodule

// File: tb/tb_pwm_slot.sv
// Self-checking bench for pwm_slot: register access, error paths,
// and PWM waveforms against a closed-form period model.
module tb_pwm_slot;
    localparam int NCH = 4;
    localparam int RB  = 8;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           arst_n;
    logic [NCH-1:0] pwm_out;

    always #5 clk = ~clk;

    pwm_slot_if bus ();

    pwm_slot #(.NUM_CH(NCH), .RES_BITS(RB), .DVSR_WIDTH(DW)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus),
        .pwm_out(pwm_out)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // model: enable, divisor, duties and the cycle at which the
    // counter was last zeroed (value of cyc after that edge)
    bit          m_en;
    int unsigned m_dvsr;
    int unsigned m_duty [NCH];
    int unsigned m_sync;

    logic [31:0] r_data;
    bit          r_wd, r_rd, r_se, r_de;
    int unsigned r_cyc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned exp_cnt(input int unsigned c);
        return ((c - m_sync) / (m_dvsr + 1)) % (1 << RB);
    endfunction

    function automatic logic [NCH-1:0] exp_pwm(input int unsigned c);
        logic [NCH-1:0] v;
        int unsigned    n;
        v = '0;
        if (!m_en) return v;
        n = exp_cnt(c - 1);
        for (int i = 0; i < NCH; i++)
            v[i] = (n < m_duty[i]);
        return v;
    endfunction

    task automatic xact(input bit rd, input bit wr,
                        input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chip_select = 1'b1;
        bus.read        = rd;
        bus.write       = wr;
        bus.addr        = a;
        bus.wr_data     = d;
        @(posedge clk); #1;
        r_cyc  = cyc;
        r_data = bus.rd_data;
        r_wd   = bus.wr_done;
        r_rd   = bus.rd_done;
        r_se   = bus.slave_error;
        r_de   = bus.decode_error;
        chk("busy", 32'(bus.idle), 32'd0);
        bus.chip_select = 1'b0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.transaction_completed = 1'b1;
        @(posedge clk); #1;
        bus.transaction_completed = 1'b0;
        chk("back_idle", {bus.idle, bus.wr_done, bus.rd_done,
            bus.slave_error, bus.decode_error}, 32'b10000);
    endtask

    task automatic wr_ok(input logic [7:0] a, input logic [31:0] d);
        xact(1'b0, 1'b1, a, d);
        chk("wr_flags", {r_wd, r_rd, r_se, r_de}, 32'b1000);
    endtask

    task automatic rd_ok(input string tag, input logic [7:0] a,
                         input logic [31:0] exp);
        xact(1'b1, 1'b0, a, 32'd0);
        chk("rd_flags", {r_wd, r_rd, r_se, r_de}, 32'b0100);
        chk(tag, r_data, exp);
    endtask

    task automatic start_pwm();
        wr_ok(8'h00, 32'h3);
        m_en   = 1'b1;
        m_sync = r_cyc + 1;
    endtask

    task automatic rd_status();
        xact(1'b1, 1'b0, 8'h10, 32'd0);
        chk("status", r_data, exp_cnt(r_cyc - 1));
    endtask

    initial begin
        int unsigned d;
        int          hi [NCH];
        int unsigned frozen;

        arst_n = 1'b0;
        bus.chip_select = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
        bus.transaction_completed = 1'b0;
        m_en = 1'b0;
        m_dvsr = 0;
        m_sync = 0;
        for (int i = 0; i < NCH; i++) m_duty[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {bus.idle, bus.wr_done, bus.rd_done,
            bus.slave_error, bus.decode_error}, 32'b10000);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk) arst_n = 1'b1;

        rd_ok("rst_ctrl", 8'h00, 32'd0);
        rd_ok("rst_dvsr", 8'h01, 32'd0);
        rd_ok("rst_duty0", 8'h02, 32'd0);

        // fixed waveform: 64/256 duty, full on, full off
        m_dvsr = 0;
        wr_ok(8'h01, 32'd0);
        m_duty[0] = 64;  wr_ok(8'h02, 32'd64);
        m_duty[1] = 256; wr_ok(8'h03, 32'd256);
        m_duty[2] = 0;   wr_ok(8'h04, 32'd0);
        m_duty[3] = 200; wr_ok(8'h05, 32'd200);
        start_pwm();
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        repeat (512) begin
            @(posedge clk); #1;
            for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
        end
        chk("hi_duty64", 32'(hi[0]), 32'd128);
        chk("hi_duty256", 32'(hi[1]), 32'd512);
        chk("hi_duty0", 32'(hi[2]), 32'd0);
        chk("hi_duty200", 32'(hi[3]), 32'd400);

        // DVSR=3: one tick per 4 clocks, observed through STATUS
        m_dvsr = 3;
        wr_ok(8'h01, 32'd3);
        start_pwm();
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 9)) @(posedge clk);
            rd_status();
        end

        // random divisors and duties, unused upper bits set
        for (int t = 0; t < 4; t++) begin
            m_dvsr = $urandom_range(0, 3);
            wr_ok(8'h01, m_dvsr | ($urandom & 32'hFFFF_0000));
            for (int i = 0; i < NCH; i++) begin
                d = $urandom_range(0, 300) | ($urandom & 32'hFFFF_FE00);
                m_duty[i] = d & 32'h1FF;
                wr_ok(8'(i + 2), d);
                rd_ok("duty_rb", 8'(i + 2), m_duty[i]);
            end
            rd_ok("dvsr_rb", 8'h01, m_dvsr);
            start_pwm();
            repeat (300) begin
                @(posedge clk); #1;
                chk("pwm", 32'(pwm_out), 32'(exp_pwm(cyc)));
            end
            rd_status();
        end

        // error paths
        xact(1'b1, 1'b0, 8'h20, 32'd0);
        chk("dec_rd_flags", {r_wd, r_rd, r_se, r_de}, 32'b0101);
        chk("dec_rd_data", r_data, 32'd0);
        xact(1'b0, 1'b1, 8'h10, 32'hFF);
        chk("st_wr_flags", {r_wd, r_rd, r_se, r_de}, 32'b1010);
        rd_status();
        xact(1'b1, 1'b1, 8'h02, 32'h11);
        chk("rdwr_flags", {r_wd, r_rd, r_se, r_de}, 32'b1010);
        xact(1'b0, 1'b1, 8'h06, 32'h11);
        chk("dec_wr_flags", {r_wd, r_rd, r_se, r_de}, 32'b1001);
        rd_ok("duty0_kept", 8'h02, m_duty[0]);

        // held DONE with an ignored second request
        @(negedge clk);
        bus.chip_select = 1'b1; bus.write = 1'b1;
        bus.addr = 8'h05; bus.wr_data = 32'h33;
        @(posedge clk); #1;
        bus.chip_select = 1'b0; bus.write = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_done", {bus.idle, bus.wr_done}, 32'b01);
            if (k == 2) begin
                bus.chip_select = 1'b1; bus.write = 1'b1;
                bus.wr_data = 32'h77;
            end
            if (k == 3) begin
                bus.chip_select = 1'b0; bus.write = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.transaction_completed = 1'b1;
        @(posedge clk); #1;
        bus.transaction_completed = 1'b0;
        chk("hold_release", {bus.idle, bus.wr_done}, 32'b10);
        m_duty[3] = 32'h33;
        rd_ok("duty3_first", 8'h05, m_duty[3]);

        // disable freezes the counter and drops the pins
        wr_ok(8'h00, 32'h0);
        frozen = exp_cnt(r_cyc);
        m_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("dis_pwm", 32'(pwm_out), 32'd0);
        xact(1'b1, 1'b0, 8'h10, 32'd0);
        chk("dis_status", r_data, frozen);

        // reset while in DONE
        @(negedge clk);
        bus.chip_select = 1'b1; bus.write = 1'b1;
        bus.addr = 8'h00; bus.wr_data = 32'h1;
        @(posedge clk); #1;
        bus.chip_select = 1'b0; bus.write = 1'b0;
        chk("pre_rst_done", 32'(bus.wr_done), 32'd1);
        @(negedge clk) arst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst", {bus.idle, bus.wr_done, bus.rd_done}, 32'b100);
        chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk) arst_n = 1'b1;
        m_en = 1'b0; m_dvsr = 0;
        for (int i = 0; i < NCH; i++) m_duty[i] = 0;
        rd_ok("post_ctrl", 8'h00, 32'd0);
        rd_ok("post_dvsr", 8'h01, 32'd0);
        for (int i = 0; i < NCH; i++)
            rd_ok("post_duty", 8'(i + 2), 32'd0);
        rd_ok("post_status", 8'h10, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
